urng_taus_pair: RTL
===================

# urng_taus_pair

Uniform random number source for the AWGN channel. Two independent three-component Tausworthe generators (taus88) run in parallel. Their 32-bit outputs are concatenated into one 64-bit word per accepted sample, which is split into the 48-bit `u0` consumed by the logarithm stage and the 16-bit `u1` consumed by the sin/cos stage. The block is the producer end of the `u0`/`u1` interface, with valid/ready flow control and runtime reseeding.

## Interface
- `SEED_A0`, 32'd12345: reset seed, generator A, component 0
- `SEED_A1`, 32'd67890: reset seed, A component 1
- `SEED_A2`, 32'd13579: reset seed, A component 2
- `SEED_B0`, 32'd24680: reset seed, B component 0
- `SEED_B1`, 32'd98765: reset seed, B component 1
- `SEED_B2`, 32'd43210: reset seed, B component 2

- `clk`  in  1  single clock, rising edge
- `rst`  in  1  asynchronous, active-high reset
- `en`  in  1  generator enable
- `seed_load`  in  1  one-cycle strobe; loads `seed_in`
- `seed_in`  in  192  {A0,A1,A2,B0,B1,B2}, A0 in MSBs
- `out_valid`  out  1  `u0`/`u1` hold a valid sample
- `out_ready`  in  1  consumer accepts the sample
- `u0`  out  48  uniform sample for log unit
- `u1`  out  16  uniform sample for sin/cos unit
- `sample_cnt`  out  32  number of accepted samples

## Operation
- Per-generator step on state (s0,s1,s2), 32-bit unsigned, with logical shifts:
  - s0' = ((s0 & FFFFFFFE) << 12) ^ (((s0 << 13) ^ s0) >> 19)
  - s1' = ((s1 & FFFFFFF8) << 4) ^ (((s1 << 2) ^ s1) >> 25)
  - s2' = ((s2 & FFFFFFF0) << 17) ^ (((s2 << 3) ^ s2) >> 11)
  - out = s0' ^ s1' ^ s2'
- Word W = {outA, outB}. `u0` = W[63:16], `u1` = W[15:0].
- Step condition: `adv = en & (~out_valid | out_ready) & ~seed_load`.
  - On `adv`, both generators step. `u0`/`u1` load from the stepped state. `out_valid` is set to 1.
  - When `out_valid & out_ready & ~adv`, `out_valid` is cleared to 0.
- Seed sanitising is applied on load and on reset parameters. A component below its minimum (s0<2, s1<8, s2<16) is replaced by its default parameter seed.
- `seed_load` has priority over everything else:
  - state is loaded from sanitised `seed_in`
  - `out_valid` is cleared to 0
  - `u0`/`u1` hold their previous value
  - `sample_cnt` is cleared to 0
- `sample_cnt` increments on every cycle with `out_valid & out_ready & ~seed_load`. It wraps from FFFFFFFF to 0.
- Holding `en` low freezes the state. A pending valid sample stays presented until it is accepted.

## Timing
- Reset values:
  - state = sanitised parameter seeds
  - `out_valid` = 0
  - `u0` = 0, `u1` = 0
  - `sample_cnt` = 0
- Reset asserted mid-stream returns to reset values immediately (asynchronously), regardless of handshake.
- Latency: with `en`=1, the first `out_valid`=1 appears on the first rising edge after `rst` deasserts.
- Seed load: `seed_load` at edge t. The first sample from the new seeds is valid after edge t+1, given `en`=1.
- Throughput: with `out_ready` held at 1, one new sample every cycle.
- Backpressure: with `out_valid`=1 and `out_ready`=0, `u0`, `u1` and the state remain stable.
- Simultaneous `seed_load` and accept: the accept is dropped (not counted) and the sample is discarded.

## Configuration
- `URNG_NONZERO_U0_EN`:
  - When defined, a `u0` value of 0 is replaced by 48'd1 at the output register, so the log stage never receives zero. The state is unaffected.
  - When undefined, `u0` is the raw W[63:16].

## Test plan
- Reset with default parameters, `en`=1, `out_ready`=1 → `out_valid` rises 1 cycle after reset release. The first 1000 `u0`/`u1` words match the C taus88 model bit-exactly, and `sample_cnt` = 1000.
- Random `out_ready` (50% duty) → `u0`/`u1` are stable while `out_valid & ~out_ready`. The sequence is identical to the free-running model, and `sample_cnt` equals the handshake count.
- `seed_load` with `seed_in` = all 0 → state equals the default seeds. The output sequence equals the post-reset sequence, and `sample_cnt` = 0 after the load.
- `seed_load` together with `out_ready`=1 while `out_valid`=1 → `out_valid`=0 the next cycle and `sample_cnt` is not incremented. The new-seed sample is valid 2 edges after the load.
- `en`=0 for 20 cycles mid-stream → no state change. Resuming continues exactly at the next model sample. Asserting `rst` mid-stream zeroes outputs asynchronously.
- With `URNG_NONZERO_U0_EN` defined, run 2^20 samples → no `u0` equals 0, and the model with substitution matches. Without the macro, the raw model matches.

Source files
------------

// File: rtl/urng_taus_pair.sv
// -----------------------------------------------------------------------------
// urng_taus_pair
//
// Uniform random number source for the AWGN channel. Two independent taus88
// (three-component Tausworthe) generators step together. Their 32-bit outputs
// form one 64-bit word W = {out_a, out_b} per produced sample. W is split into
// a 48-bit u0 for the logarithm stage and a 16-bit u1 for the sin/cos stage.
// The output side is a valid/ready producer. The generator state can be
// reseeded at run time.
//
// Configuration macro:
//   URNG_NONZERO_U0_EN - when defined, a u0 value of zero is replaced by 48'd1
//                        in the output register, so the log stage never sees
//                        zero. The generator state is not affected.
//
// Ports:
//   clk        in   1    single clock, rising edge
//   rst        in   1    asynchronous, active-high reset
//   en         in   1    generator enable; low freezes the state
//   seed_load  in   1    one-cycle strobe, loads seed_in (highest priority)
//   seed_in    in   192  {A0,A1,A2,B0,B1,B2}, A0 in the MSBs
//   out_valid  out  1    u0/u1 hold a valid sample
//   out_ready  in   1    consumer accepts the sample
//   u0         out  48   W[63:16], uniform sample for the log unit
//   u1         out  16   W[15:0], uniform sample for the sin/cos unit
//   sample_cnt out  32   number of accepted samples, wraps at 2^32
// -----------------------------------------------------------------------------
module urng_taus_pair #(
  parameter logic [31:0] SEED_A0 = 32'd12345,
  parameter logic [31:0] SEED_A1 = 32'd67890,
  parameter logic [31:0] SEED_A2 = 32'd13579,
  parameter logic [31:0] SEED_B0 = 32'd24680,
  parameter logic [31:0] SEED_B1 = 32'd98765,
  parameter logic [31:0] SEED_B2 = 32'd43210
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic         seed_load,
  input  logic [191:0] seed_in,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [47:0]  u0,
  output logic [15:0]  u1,
  output logic [31:0]  sample_cnt
);

  // One taus88 generator: three 32-bit components.
  typedef struct packed {
    logic [31:0] s0;
    logic [31:0] s1;
    logic [31:0] s2;
  } taus_state_t;

  // Components below these values fall into short cycles (the masked low bits
  // are discarded by the recurrence), so they are never allowed into the state.
  localparam logic [31:0] MIN_S0 = 32'd2;
  localparam logic [31:0] MIN_S1 = 32'd8;
  localparam logic [31:0] MIN_S2 = 32'd16;

  // One taus88 step. All shifts are logical on 32-bit values; bits shifted
  // past bit 31 are discarded by the 32-bit assignment targets.
  function automatic taus_state_t taus_step(input taus_state_t s);
    taus_state_t n;
    n.s0 = ((s.s0 & 32'hFFFF_FFFE) << 12) ^ (((s.s0 << 13) ^ s.s0) >> 19);
    n.s1 = ((s.s1 & 32'hFFFF_FFF8) << 4)  ^ (((s.s1 << 2)  ^ s.s1) >> 25);
    n.s2 = ((s.s2 & 32'hFFFF_FFF0) << 17) ^ (((s.s2 << 3)  ^ s.s2) >> 11);
    return n;
  endfunction

  function automatic logic [31:0] taus_out(input taus_state_t s);
    return s.s0 ^ s.s1 ^ s.s2;
  endfunction

  // Replace any component below its minimum by the matching default seed.
  function automatic taus_state_t sanitize(input taus_state_t s,
                                           input taus_state_t dflt);
    taus_state_t r;
    r.s0 = (s.s0 < MIN_S0) ? dflt.s0 : s.s0;
    r.s1 = (s.s1 < MIN_S1) ? dflt.s1 : s.s1;
    r.s2 = (s.s2 < MIN_S2) ? dflt.s2 : s.s2;
    return r;
  endfunction

  localparam taus_state_t DFLT_A = {SEED_A0, SEED_A1, SEED_A2};
  localparam taus_state_t DFLT_B = {SEED_B0, SEED_B1, SEED_B2};
  localparam taus_state_t RESET_A = sanitize(DFLT_A, DFLT_A);
  localparam taus_state_t RESET_B = sanitize(DFLT_B, DFLT_B);

  // ---------------------------------------------------------------------------
  // Generator state and combinational next values
  // ---------------------------------------------------------------------------
  taus_state_t st_a;
  taus_state_t st_b;

  taus_state_t next_a;
  taus_state_t next_b;
  taus_state_t load_a;
  taus_state_t load_b;
  logic [63:0] word;
  logic [47:0] u0_next;
  logic        adv;
  logic        accept;

  // A new sample is produced when enabled and the output register is free or
  // being emptied this cycle. A seed load suppresses both stepping and
  // acceptance, so a sample presented during a load is discarded uncounted.
  assign adv    = en & (~out_valid | out_ready) & ~seed_load;
  assign accept = out_valid & out_ready & ~seed_load;

  // NOTE: every signal assigned in this always_comb gets a default first, so
  // no path leaves it unassigned and no latch is inferred.
  always_comb begin
    next_a  = taus_step(st_a);
    next_b  = taus_step(st_b);
    load_a  = sanitize(taus_state_t'(seed_in[191:96]), DFLT_A);
    load_b  = sanitize(taus_state_t'(seed_in[95:0]),   DFLT_B);
    word    = {taus_out(next_a), taus_out(next_b)};
    u0_next = word[63:16];
`ifdef URNG_NONZERO_U0_EN
    // Zero would make the downstream logarithm diverge; substitute the
    // smallest nonzero value. Only the output register sees this.
    if (word[63:16] == 48'd0) begin
      u0_next = 48'd1;
    end
`endif
  end

  // ---------------------------------------------------------------------------
  // State, output register and accepted-sample counter
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st_a       <= RESET_A;
      st_b       <= RESET_B;
      out_valid  <= 1'b0;
      u0         <= '0;
      u1         <= '0;
      sample_cnt <= '0;
    end else if (seed_load) begin
      // u0/u1 deliberately keep their value; out_valid already hides them.
      st_a       <= load_a;
      st_b       <= load_b;
      out_valid  <= 1'b0;
      sample_cnt <= '0;
    end else begin
      if (adv) begin
        st_a      <= next_a;
        st_b      <= next_b;
        u0        <= u0_next;
        u1        <= word[15:0];
        out_valid <= 1'b1;
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end

      if (accept) begin
        sample_cnt <= sample_cnt + 32'd1;
      end
    end
  end

endmodule
